axi_ic_resp_rr: RTL and testbench
=================================

// Module: axi_ic_resp_rr
// PURPOSE
// Read-response (R channel) router of the AXI interconnect, parametrised in master count, slave count, ID and data width.
// Routes each slave R beat to the master encoded in the upper ID bits of the response ID.
// Per master: round-robin arbitration between slaves, locked for a whole burst until RLAST.
// Per master: 2-entry output buffer and an outstanding-read counter, fed by the AR handshakes.
// Responses with no outstanding read are dropped and flagged. Sits between slave R ports and master R ports.
// PARAMETERS
// MSTRS      2   number of master ports
// SLVS       4   number of slave ports
// MSTR_BITS  1   master index bits appended above master ID (>= clog2(MSTRS))
// ID_BITS    4   master-side ID width; slave-side ID is ID_BITS+MSTR_BITS (SID_BITS)
// DATA_BITS  64  RDATA width
// OUTS_BITS  3   outstanding-read counter width per master (max 2**OUTS_BITS-1)
// PORTS
// clk        in   1                 clock, all logic rising-edge
// reset      in   1                 asynchronous, active-high reset
// S_RID      in   SLVS*SID_BITS     slave response IDs, [SID_BITS-1:ID_BITS] = master index
// S_RDATA    in   SLVS*DATA_BITS    slave read data
// S_RRESP    in   SLVS*2            slave response code
// S_RLAST    in   SLVS              slave last beat
// S_RVALID   in   SLVS              slave beat valid
// S_RREADY   out  SLVS              slave beat accepted
// M_RID      out  MSTRS*ID_BITS     master response IDs (lower ID_BITS of S_RID)
// M_RDATA    out  MSTRS*DATA_BITS   master read data
// M_RRESP    out  MSTRS*2           master response code
// M_RLAST    out  MSTRS             master last beat
// M_RVALID   out  MSTRS             master beat valid
// M_RREADY   in   MSTRS             master ready
// M_ARVALID  in   MSTRS             master AR valid (monitor only)
// M_ARREADY  in   MSTRS             master AR ready (monitor only)
// cmd_full   out  MSTRS             outstanding counter at max; upstream must hold AR
// err_stray  out  1                 one-cycle pulse: response dropped (no outstanding read)
// BEHAVIOUR
// - Reset: buffers empty, M_RVALID=0, counters=0, RR pointers=0, locks clear, cmd_full=0, err_stray=0. Mid-burst reset discards buffered beats and locks.
// - Routing: beat of slave s targets master m = S_RID[s][SID_BITS-1:ID_BITS]; index >= MSTRS is treated as stray.
// - Arbitration per master m:
//   - Requesters are slaves with S_RVALID targeting m while cnt[m] != 0.
//   - Unlocked: grant the first requester at or after ptr[m], wrapping at SLVS.
//   - Locked: grant stays with the locked slave until its RLAST beat transfers; then ptr[m] = granted+1 (mod SLVS) and the lock clears.
//   - Non-last transfer sets the lock; a single-beat burst never locks.
// - S_RREADY[s] = (granted by m AND buffer[m] count<2) OR beat is stray. Combinational, independent of M_RREADY.
// - Stray: S_RREADY=1 and the beat is dropped. err_stray=1 the next cycle (registered, OR over slaves); no buffer or counter change.
// - Buffer: 2-entry FIFO per master, push on S_RVALID&S_RREADY of granted slave, pop on M_RVALID&M_RREADY.
//   - Latency 1: beat accepted in cycle N is on M_* in cycle N+1 if buffer was empty. Push+pop same cycle allowed; full throughput 1 beat/clk.
//   - M_RVALID = buffer non-empty; M_* fields stable while M_RVALID&!M_RREADY.
// - Counter per master: +1 on M_ARVALID&M_ARREADY; -1 on push of a beat with RLAST; both in the same cycle -> unchanged.
//   - cmd_full = (cnt == 2**OUTS_BITS-1). An AR handshake while full is ignored (counter saturates).
// - Independent masters proceed in parallel; one slave is granted by at most one master (its routed master).
// TESTING
// - Slave 0 sends 4-beat burst ID {1,4'h3} after one AR on M1 -> M1 sees 4 beats, RID=3, RLAST on 4th, first beat 1 clk after accept, cnt[1] 1->0.
// - Slaves 1,2 both valid to M0 (2 ARs), 2-beat bursts each, ptr=0 -> slave1 burst wholly, then slave2; no interleave; ptr[0]=3 at end.
// - M0 RREADY low 5 clks during burst -> buffer fills to 2, S_RREADY drops, no beat lost or duplicated, stall releases 1 clk after RREADY.
// - Response to M1 with cnt[1]=0 -> S_RREADY=1, nothing on M1, err_stray pulses 1 clk.
// - 7 ARs on M0 with no responses -> cmd_full[0]=1; 8th AR ignored; AR and RLAST push same cycle -> cnt unchanged.
// - Assert reset mid-burst with 2 beats buffered -> M_RVALID=0 immediately, cnt=0, next burst arbitrated from ptr=0.

Source files
------------

// File: rtl/axi_ic_resp_rr.sv
// axi_ic_resp_rr: AXI read-response router for the interconnect.
// Slave R beats are steered to the master named in the upper RID bits.
// Each master has a round-robin arbiter between slaves that holds a burst
// until RLAST, a 2-entry output FIFO, and an outstanding-read counter fed
// by its AR handshakes. Beats with no outstanding read are dropped and
// flagged on err_stray.
module axi_ic_resp_rr #(
  parameter  int MSTRS     = 2,
  parameter  int SLVS      = 4,
  parameter  int MSTR_BITS = 1,
  parameter  int ID_BITS   = 4,
  parameter  int DATA_BITS = 64,
  parameter  int OUTS_BITS = 3,
  localparam int SID_BITS  = ID_BITS + MSTR_BITS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [SLVS*SID_BITS-1:0]   S_RID,
  input  logic [SLVS*DATA_BITS-1:0]  S_RDATA,
  input  logic [SLVS*2-1:0]          S_RRESP,
  input  logic [SLVS-1:0]            S_RLAST,
  input  logic [SLVS-1:0]            S_RVALID,
  output logic [SLVS-1:0]            S_RREADY,
  output logic [MSTRS*ID_BITS-1:0]   M_RID,
  output logic [MSTRS*DATA_BITS-1:0] M_RDATA,
  output logic [MSTRS*2-1:0]         M_RRESP,
  output logic [MSTRS-1:0]           M_RLAST,
  output logic [MSTRS-1:0]           M_RVALID,
  input  logic [MSTRS-1:0]           M_RREADY,
  input  logic [MSTRS-1:0]           M_ARVALID,
  input  logic [MSTRS-1:0]           M_ARREADY,
  output logic [MSTRS-1:0]           cmd_full,
  output logic                       err_stray
);

  localparam int PTR_W  = (SLVS > 1) ? $clog2(SLVS) : 1;
  localparam int SCAN_W = PTR_W + 1;
  // FIFO entry layout: {rid, rdata, rresp, rlast}
  localparam int ENT_W  = ID_BITS + DATA_BITS + 2 + 1;

  // Target master index of every slave's current beat
  logic [SLVS*MSTR_BITS-1:0] w_tgt;
  // Per master m, bit m*SLVS+s: slave s requests m / slave s beat accepted by m
  logic [MSTRS*SLVS-1:0]     w_req_flat;
  logic [MSTRS*SLVS-1:0]     w_acc_flat;
  logic [SLVS-1:0]           w_any_req;
  logic [SLVS-1:0]           w_acc_any;
  logic [SLVS-1:0]           w_stray;
  logic                      r_err;

  genvar gi;

  generate
    for (gi = 0; gi < SLVS; gi++) begin : g_slv
      assign w_tgt[gi*MSTR_BITS +: MSTR_BITS] = S_RID[gi*SID_BITS + ID_BITS +: MSTR_BITS];
    end
  endgenerate

  // Fold per-master request/accept matrices down to per-slave flags
  always_comb begin
    w_any_req = '0;
    w_acc_any = '0;
    for (int s = 0; s < SLVS; s++) begin
      for (int m = 0; m < MSTRS; m++) begin
        w_any_req[s] = w_any_req[s] | w_req_flat[m*SLVS + s];
        w_acc_any[s] = w_acc_any[s] | w_acc_flat[m*SLVS + s];
      end
    end
  end

  // A valid beat nobody can take (bad index or no outstanding read) is stray
  assign w_stray  = S_RVALID & ~w_any_req;
  assign S_RREADY = w_acc_any | w_stray;

  // Stray indication is a registered one-cycle pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_err <= 1'b0;
    else       r_err <= |w_stray;
  end

  assign err_stray = r_err;

  generate
    for (gi = 0; gi < MSTRS; gi++) begin : g_mstr
      logic [SLVS-1:0]      w_req;
      logic                 w_gnt_vld;
      logic [PTR_W-1:0]     w_gnt_idx;
      logic [SCAN_W-1:0]    w_scan;
      logic [PTR_W-1:0]     w_ptr_next;
      logic [ENT_W-1:0]     w_ent;
      logic [ENT_W-1:0]     w_head;
      logic                 w_push;
      logic                 w_pop;
      logic                 w_inc;
      logic                 w_dec;
      logic [OUTS_BITS-1:0] r_cnt;
      logic [PTR_W-1:0]     r_ptr;
      logic [PTR_W-1:0]     r_lock_slv;
      logic                 r_lock;
      logic [ENT_W-1:0]     r_buf [2];
      logic                 r_wr;
      logic                 r_rd;
      logic [1:0]           r_count;

      // Slaves routed here may only compete while a read is outstanding
      always_comb begin
        w_req = '0;
        for (int s = 0; s < SLVS; s++) begin
          w_req[s] = S_RVALID[s] && (w_tgt[s*MSTR_BITS +: MSTR_BITS] == MSTR_BITS'(gi))
                     && (r_cnt != '0);
        end
      end

      // Locked: stay on the burst owner. Unlocked: first requester at/after r_ptr.
      // The scan runs from the farthest offset down so the nearest one wins.
      always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = r_ptr;
        w_scan    = '0;
        if (r_lock) begin
          w_gnt_idx = r_lock_slv;
          w_gnt_vld = w_req[r_lock_slv];
        end else begin
          for (int k = SLVS - 1; k >= 0; k--) begin
            w_scan = {1'b0, r_ptr} + SCAN_W'(k);
            if (w_scan >= SCAN_W'(SLVS)) w_scan = w_scan - SCAN_W'(SLVS);
            if (w_req[w_scan[PTR_W-1:0]]) begin
              w_gnt_vld = 1'b1;
              w_gnt_idx = w_scan[PTR_W-1:0];
            end
          end
        end
      end

      assign w_ent = {S_RID[32'(w_gnt_idx)*SID_BITS +: ID_BITS],
                      S_RDATA[32'(w_gnt_idx)*DATA_BITS +: DATA_BITS],
                      S_RRESP[32'(w_gnt_idx)*2 +: 2],
                      S_RLAST[w_gnt_idx]};

      assign w_push     = w_gnt_vld && (r_count != 2'd2);
      assign w_pop      = (r_count != 2'd0) && M_RREADY[gi];
      // AR handshakes at the saturation value are not counted
      assign w_inc      = M_ARVALID[gi] && M_ARREADY[gi] && (r_cnt != '1);
      assign w_dec      = w_push && w_ent[0];
      assign w_ptr_next = (w_gnt_idx == PTR_W'(SLVS - 1)) ? '0 : w_gnt_idx + 1'b1;

      assign w_req_flat[gi*SLVS +: SLVS] = w_req;
      assign w_acc_flat[gi*SLVS +: SLVS] = w_push ? (SLVS'(1) << w_gnt_idx) : '0;

      // FIFO storage, no reset needed: r_count qualifies every entry
      always_ff @(posedge clk) begin
        if (w_push) r_buf[r_wr] <= w_ent;
      end

      // FIFO pointers, arbitration state and outstanding-read counter
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_wr       <= 1'b0;
          r_rd       <= 1'b0;
          r_count    <= 2'd0;
          r_ptr      <= '0;
          r_lock     <= 1'b0;
          r_lock_slv <= '0;
          r_cnt      <= '0;
        end else begin
          if (w_push) r_wr <= ~r_wr;
          if (w_pop)  r_rd <= ~r_rd;
          r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
          if (w_push) begin
            if (w_ent[0]) begin
              r_lock <= 1'b0;
              r_ptr  <= w_ptr_next;
            end else begin
              r_lock     <= 1'b1;
              r_lock_slv <= w_gnt_idx;
            end
          end
          case ({w_inc, w_dec})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
          endcase
        end
      end

      assign w_head = r_buf[r_rd];
      assign M_RID[gi*ID_BITS +: ID_BITS]       = w_head[ENT_W-1 -: ID_BITS];
      assign M_RDATA[gi*DATA_BITS +: DATA_BITS] = w_head[3 +: DATA_BITS];
      assign M_RRESP[gi*2 +: 2]                 = w_head[2:1];
      assign M_RLAST[gi]                        = w_head[0];
      assign M_RVALID[gi]                       = (r_count != 2'd0);
      assign cmd_full[gi]                       = (r_cnt == '1);
    end
  endgenerate

endmodule

// File: tb/tb_axi_ic_resp_rr.sv
// tb_axi_ic_resp_rr: directed scenarios for the R-channel router with
// per-slave beat queues and per-master receive queues.
module tb_axi_ic_resp_rr;

  typedef struct packed {
    logic [4:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [19:0]  S_RID;
  logic [255:0] S_RDATA;
  logic [7:0]   S_RRESP;
  logic [3:0]   S_RLAST, S_RVALID, S_RREADY;
  logic [7:0]   M_RID;
  logic [127:0] M_RDATA;
  logic [3:0]   M_RRESP;
  logic [1:0]   M_RLAST, M_RVALID, M_RREADY, M_ARVALID, M_ARREADY, cmd_full;
  logic         err_stray;

  beat_t sq [4][$];
  beat_t rq [2][$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_err    = 0;

  axi_ic_resp_rr dut (
    .clk(clk), .reset(reset),
    .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RLAST(S_RLAST),
    .S_RVALID(S_RVALID), .S_RREADY(S_RREADY),
    .M_RID(M_RID), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RLAST(M_RLAST),
    .M_RVALID(M_RVALID), .M_RREADY(M_RREADY),
    .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .cmd_full(cmd_full), .err_stray(err_stray)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

  function automatic beat_t mk(input logic [4:0] id, input logic [63:0] d, input logic l);
    beat_t b;
    b.id = id; b.data = d; b.resp = d[1:0]; b.last = l;
    return b;
  endfunction

  task automatic drive();
    for (int s = 0; s < 4; s++) begin
      if (sq[s].size() != 0) begin
        S_RVALID[s]          = 1'b1;
        S_RID[s*5 +: 5]      = sq[s][0].id;
        S_RDATA[s*64 +: 64]  = sq[s][0].data;
        S_RRESP[s*2 +: 2]    = sq[s][0].resp;
        S_RLAST[s]           = sq[s][0].last;
      end else begin
        S_RVALID[s] = 1'b0;
        S_RLAST[s]  = 1'b0;
      end
    end
  endtask

  // One clock: record handshakes before the edge, then update slave drives
  task automatic tick();
    logic [3:0] xfer;
    beat_t b;
    xfer = S_RVALID & S_RREADY;
    if (!reset) begin
      for (int m = 0; m < 2; m++) begin
        if (M_RVALID[m] && M_RREADY[m]) begin
          b.id   = {m[0], M_RID[m*4 +: 4]};
          b.data = M_RDATA[m*64 +: 64];
          b.resp = M_RRESP[m*2 +: 2];
          b.last = M_RLAST[m];
          rq[m].push_back(b);
          $display("rx m%0d rid=%h data=%h resp=%0d last=%b", m, b.id[3:0], b.data, b.resp, b.last);
        end
      end
    end
    @(posedge clk); #1;
    if (err_stray) n_err++;
    for (int s = 0; s < 4; s++)
      if (xfer[s] && sq[s].size() != 0) b = sq[s].pop_front();
    drive();
    #1;
  endtask

  task automatic ar(input int m, input int n);
    M_ARVALID[m] = 1'b1;
    repeat (n) tick();
    M_ARVALID[m] = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++; if (M_RVALID !== 2'b00) $display("FAIL rst_rvalid: got %b want 00", M_RVALID); else n_pass++;
    n_checks++; if (cmd_full !== 2'b00) $display("FAIL rst_cmd_full: got %b want 00", cmd_full); else n_pass++;
    n_checks++; if (err_stray !== 1'b0) $display("FAIL rst_err: got %b want 0", err_stray); else n_pass++;
    n_checks++; if (S_RREADY !== 4'h0) $display("FAIL rst_srready: got %b want 0000", S_RREADY); else n_pass++;
    @(posedge clk); #1; reset = 1'b0; #1;
    tick();
    n_checks++; if (M_RVALID !== 2'b00) $display("FAIL post_rst_rvalid: got %b want 00", M_RVALID); else n_pass++;
  endtask

  task automatic test_single_burst();
    for (int k = 0; k < 4; k++) sq[0].push_back(mk(5'h13, 64'hA000 + 64'(k), k == 3));
    M_ARVALID[1] = 1'b1;
    tick();
    M_ARVALID[1] = 1'b0;
    n_checks++; if (S_RREADY[0] !== 1'b1) $display("FAIL sb_srready: got %b want 1", S_RREADY[0]); else n_pass++;
    n_checks++; if (M_RVALID[1] !== 1'b0) $display("FAIL sb_lat0: got %b want 0", M_RVALID[1]); else n_pass++;
    tick();
    n_checks++; if (M_RVALID[1] !== 1'b1) $display("FAIL sb_lat1: got %b want 1", M_RVALID[1]); else n_pass++;
    n_checks++; if (M_RID[7:4] !== 4'h3) $display("FAIL sb_rid: got %h want 3", M_RID[7:4]); else n_pass++;
    n_checks++; if (M_RDATA[127:64] !== 64'hA000) $display("FAIL sb_data0: got %h want a000", M_RDATA[127:64]); else n_pass++;
    repeat (6) tick();
    n_checks++; if (rq[1].size() != 4) $display("FAIL sb_count: got %0d want 4", rq[1].size()); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (rq[1][k] !== mk(5'h13, 64'hA000 + 64'(k), k == 3))
        $display("FAIL sb_beat%0d: got %h want %h", k, rq[1][k], mk(5'h13, 64'hA000 + 64'(k), k == 3));
      else n_pass++;
    end
    n_checks++; if (rq[0].size() != 0) $display("FAIL sb_m0_quiet: got %0d want 0", rq[0].size()); else n_pass++;
  endtask

  task automatic test_stray();
    int e0;
    e0 = n_err;
    sq[1].push_back(mk(5'h1A, 64'h5555, 1'b1));
    tick();
    n_checks++; if (S_RREADY[1] !== 1'b1) $display("FAIL st_srready: got %b want 1", S_RREADY[1]); else n_pass++;
    n_checks++; if (err_stray !== 1'b0) $display("FAIL st_err_early: got %b want 0", err_stray); else n_pass++;
    tick();
    n_checks++; if (err_stray !== 1'b1) $display("FAIL st_err_pulse: got %b want 1", err_stray); else n_pass++;
    n_checks++; if (M_RVALID[1] !== 1'b0) $display("FAIL st_m1_valid: got %b want 0", M_RVALID[1]); else n_pass++;
    tick();
    n_checks++; if (err_stray !== 1'b0) $display("FAIL st_err_end: got %b want 0", err_stray); else n_pass++;
    n_checks++; if (n_err - e0 != 1) $display("FAIL st_err_count: got %0d want 1", n_err - e0); else n_pass++;
    n_checks++; if (rq[1].size() != 4) $display("FAIL st_m1_count: got %0d want 4", rq[1].size()); else n_pass++;
  endtask

  task automatic test_round_robin();
    beat_t exp_q [$];
    rq[0].delete();
    ar(0, 2);
    for (int k = 0; k < 2; k++) begin
      sq[1].push_back(mk(5'h01, 64'hB100 + 64'(k), k == 1));
      sq[2].push_back(mk(5'h02, 64'hB200 + 64'(k), k == 1));
    end
    repeat (8) tick();
    exp_q = '{mk(5'h01, 64'hB100, 1'b0), mk(5'h01, 64'hB101, 1'b1),
              mk(5'h02, 64'hB200, 1'b0), mk(5'h02, 64'hB201, 1'b1)};
    n_checks++; if (rq[0].size() != 4) $display("FAIL rr_count: got %0d want 4", rq[0].size()); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++; if (rq[0][k] !== exp_q[k]) $display("FAIL rr_beat%0d: got %h want %h", k, rq[0][k], exp_q[k]); else n_pass++;
    end
    // pointer now 3: slave 3 must beat slave 0
    rq[0].delete();
    ar(0, 2);
    sq[0].push_back(mk(5'h04, 64'hC000, 1'b1));
    sq[3].push_back(mk(5'h07, 64'hC300, 1'b1));
    repeat (5) tick();
    n_checks++; if (rq[0].size() != 2) $display("FAIL rr_ptr_count: got %0d want 2", rq[0].size()); else n_pass++;
    n_checks++; if (rq[0][0] !== mk(5'h07, 64'hC300, 1'b1)) $display("FAIL rr_ptr_first: got %h want %h", rq[0][0], mk(5'h07, 64'hC300, 1'b1)); else n_pass++;
    n_checks++; if (rq[0][1] !== mk(5'h04, 64'hC000, 1'b1)) $display("FAIL rr_ptr_second: got %h want %h", rq[0][1], mk(5'h04, 64'hC000, 1'b1)); else n_pass++;
  endtask

  task automatic test_stall();
    rq[0].delete();
    ar(0, 1);
    for (int k = 0; k < 4; k++) sq[1].push_back(mk(5'h05, 64'hD100 + 64'(k), k == 3));
    tick();
    M_RREADY[0] = 1'b0;
    tick();
    n_checks++; if (S_RREADY[1] !== 1'b1) $display("FAIL stl_room: got %b want 1", S_RREADY[1]); else n_pass++;
    tick();
    n_checks++; if (S_RREADY[1] !== 1'b0) $display("FAIL stl_full: got %b want 0", S_RREADY[1]); else n_pass++;
    n_checks++; if (M_RVALID[0] !== 1'b1) $display("FAIL stl_valid: got %b want 1", M_RVALID[0]); else n_pass++;
    repeat (3) tick();
    n_checks++; if (M_RDATA[63:0] !== 64'hD100) $display("FAIL stl_hold: got %h want d100", M_RDATA[63:0]); else n_pass++;
    M_RREADY[0] = 1'b1; #1;
    n_checks++; if (S_RREADY[1] !== 1'b0) $display("FAIL stl_no_comb_path: got %b want 0", S_RREADY[1]); else n_pass++;
    tick();
    n_checks++; if (S_RREADY[1] !== 1'b1) $display("FAIL stl_release: got %b want 1", S_RREADY[1]); else n_pass++;
    repeat (6) tick();
    n_checks++; if (rq[0].size() != 4) $display("FAIL stl_count: got %0d want 4", rq[0].size()); else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (rq[0][k] !== mk(5'h05, 64'hD100 + 64'(k), k == 3))
        $display("FAIL stl_beat%0d: got %h want %h", k, rq[0][k], mk(5'h05, 64'hD100 + 64'(k), k == 3));
      else n_pass++;
    end
  endtask

  task automatic test_cmd_full();
    int e0;
    rq[0].delete();
    e0 = n_err;
    M_ARVALID[0] = 1'b1;
    repeat (6) tick();
    n_checks++; if (cmd_full[0] !== 1'b0) $display("FAIL cf_six: got %b want 0", cmd_full[0]); else n_pass++;
    tick();
    n_checks++; if (cmd_full[0] !== 1'b1) $display("FAIL cf_seven: got %b want 1", cmd_full[0]); else n_pass++;
    tick();
    M_ARVALID[0] = 1'b0;
    n_checks++; if (cmd_full[0] !== 1'b1) $display("FAIL cf_saturate: got %b want 1", cmd_full[0]); else n_pass++;
    sq[0].push_back(mk(5'h00, 64'hE000, 1'b1));
    tick(); tick();
    n_checks++; if (cmd_full[0] !== 1'b0) $display("FAIL cf_dec: got %b want 0", cmd_full[0]); else n_pass++;
    sq[0].push_back(mk(5'h00, 64'hE001, 1'b1));
    tick();
    M_ARVALID[0] = 1'b1;
    tick();
    M_ARVALID[0] = 1'b0;
    n_checks++; if (cmd_full[0] !== 1'b0) $display("FAIL cf_same_cycle: got %b want 0", cmd_full[0]); else n_pass++;
    ar(0, 1);
    n_checks++; if (cmd_full[0] !== 1'b1) $display("FAIL cf_refill: got %b want 1", cmd_full[0]); else n_pass++;
    for (int k = 0; k < 8; k++) sq[0].push_back(mk(5'h00, 64'hE010 + 64'(k), 1'b1));
    repeat (12) tick();
    n_checks++; if (rq[0].size() != 9) $display("FAIL cf_drain_count: got %0d want 9", rq[0].size()); else n_pass++;
    n_checks++; if (n_err - e0 != 1) $display("FAIL cf_stray_count: got %0d want 1", n_err - e0); else n_pass++;
    n_checks++; if (rq[0][8] !== mk(5'h00, 64'hE016, 1'b1)) $display("FAIL cf_last_beat: got %h want %h", rq[0][8], mk(5'h00, 64'hE016, 1'b1)); else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    beat_t b;
    int e0;
    rq[0].delete();
    ar(0, 1);
    for (int k = 0; k < 4; k++) sq[2].push_back(mk(5'h06, 64'hF200 + 64'(k), k == 3));
    M_RREADY[0] = 1'b0;
    tick(); tick(); tick();
    n_checks++; if (S_RREADY[2] !== 1'b0) $display("FAIL mr_full: got %b want 0", S_RREADY[2]); else n_pass++;
    reset = 1'b1;
    for (int s = 0; s < 4; s++) while (sq[s].size() != 0) b = sq[s].pop_front();
    drive();
    #1;
    n_checks++; if (M_RVALID !== 2'b00) $display("FAIL mr_valid_clr: got %b want 00", M_RVALID); else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    M_RREADY[0] = 1'b1;
    #1;
    e0 = n_err;
    sq[3].push_back(mk(5'h00, 64'hF300, 1'b1));
    repeat (3) tick();
    n_checks++; if (n_err - e0 != 1) $display("FAIL mr_cnt_clr: got %0d stray want 1", n_err - e0); else n_pass++;
    n_checks++; if (rq[0].size() != 0) $display("FAIL mr_no_beats: got %0d want 0", rq[0].size()); else n_pass++;
    ar(0, 2);
    sq[0].push_back(mk(5'h08, 64'h6000, 1'b1));
    sq[3].push_back(mk(5'h09, 64'h6300, 1'b1));
    repeat (5) tick();
    n_checks++; if (rq[0].size() != 2) $display("FAIL mr_ptr_count: got %0d want 2", rq[0].size()); else n_pass++;
    n_checks++; if (rq[0][0] !== mk(5'h08, 64'h6000, 1'b1)) $display("FAIL mr_ptr_first: got %h want %h", rq[0][0], mk(5'h08, 64'h6000, 1'b1)); else n_pass++;
  endtask

  task automatic test_parallel();
    rq[0].delete();
    rq[1].delete();
    M_ARVALID = 2'b11;
    tick();
    M_ARVALID = 2'b00;
    for (int k = 0; k < 2; k++) begin
      sq[0].push_back(mk(5'h1B, 64'h7000 + 64'(k), k == 1));
      sq[3].push_back(mk(5'h0C, 64'h7300 + 64'(k), k == 1));
    end
    tick();
    n_checks++; if (S_RREADY !== 4'b1001) $display("FAIL par_srready: got %b want 1001", S_RREADY); else n_pass++;
    tick();
    n_checks++; if (M_RVALID !== 2'b11) $display("FAIL par_valid: got %b want 11", M_RVALID); else n_pass++;
    repeat (5) tick();
    for (int k = 0; k < 2; k++) begin
      n_checks++; if (rq[0][k] !== mk(5'h0C, 64'h7300 + 64'(k), k == 1)) $display("FAIL par_m0_beat%0d: got %h", k, rq[0][k]); else n_pass++;
      n_checks++; if (rq[1][k] !== mk(5'h1B, 64'h7000 + 64'(k), k == 1)) $display("FAIL par_m1_beat%0d: got %h", k, rq[1][k]); else n_pass++;
    end
  endtask

  initial begin
    reset     = 1'b1;
    S_RID     = '0;
    S_RDATA   = '0;
    S_RRESP   = '0;
    S_RLAST   = '0;
    S_RVALID  = '0;
    M_RREADY  = 2'b11;
    M_ARVALID = 2'b00;
    M_ARREADY = 2'b11;
    repeat (3) @(posedge clk);
    #2;
    test_reset();
    test_single_burst();
    test_stray();
    test_round_robin();
    test_stall();
    test_cmd_full();
    test_reset_mid_burst();
    test_parallel();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
